div_result_bcd_formatter: RTL and testbench

// - Downstream stage of the 8-bit signed restoring divider: consumes its quotient/remainder pair, emits sign + 3-digit BCD per value.
// - Sequential double-dabble on both values in parallel, valid/ready on input and output; feeds display/readout logic.
// - One result in flight; no input accepted until current output is taken.

---
 rtl/div_result_bcd_formatter.sv | 181 ++++++++++++++++++
 tb/tb_div_result_bcd_formatter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_bcd_formatter.sv
// div_result_bcd_formatter
// Takes the quotient/remainder pair from the 8-bit signed restoring divider.
// Converts each value to a sign bit and a 3-digit BCD magnitude.
// Both conversions run side by side as a sequential double-dabble.
// Only one result is held at a time. A new pair is accepted only after the
// current result has been taken.
//
// Optional feature macro: DIVZ_FLAG_EN. When it is defined, the block gets a
// divide-by-zero flag path: the in_divz input and the out_divz output.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready         input handshake for the quotient/remainder pair
//   in_quo, in_rem [DATA_W]     signed quotient and remainder
//   out_valid / out_ready       output handshake for the formatted result
//   out_quo_neg, out_quo_bcd    quotient sign and 3-digit BCD magnitude
//   out_rem_neg, out_rem_bcd    remainder sign and 3-digit BCD magnitude
//   in_divz, out_divz           divide-by-zero flag (DIVZ_FLAG_EN only)
module div_result_bcd_formatter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_quo,
  input  logic [DATA_W-1:0] in_rem,
`ifdef DIVZ_FLAG_EN
  input  logic              in_divz,
  output logic              out_divz,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_quo_neg,
  output logic [11:0]       out_quo_bcd,
  output logic              out_rem_neg,
  output logic [11:0]       out_rem_bcd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_quoNeg;
  logic                r_remNeg;
  logic [DATA_W-1:0]   r_quoMag;
  logic [DATA_W-1:0]   r_remMag;
  logic [11:0]         r_quoBcd;
  logic [11:0]         r_remBcd;
  logic                w_convDone;
`ifdef DIVZ_FLAG_EN
  logic                r_divz;
`endif

  // Double-dabble correction step: any BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [11:0] addThree(input logic [11:0] bcd);
    logic [11:0] res;
    for (int d = 0; d < 3; d++) begin
      res[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
    end
    return res;
  endfunction

  // The last CONV edge is the one where the count reaches DATA_W-1.
  // A flagged divide-by-zero spends a single cycle in CONV.
`ifdef DIVZ_FLAG_EN
  assign w_convDone = (r_cnt == 4'(DATA_W - 1)) || r_divz;
`else
  assign w_convDone = (r_cnt == 4'(DATA_W - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = CONV;
      CONV:    if (w_convDone) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath.
  // On the accept edge the signs and magnitudes are latched.
  // The magnitude is 0-x taken as unsigned, so the most negative value maps to 2^(DATA_W-1).
  // In CONV, {bcd, mag} is corrected and then shifted left once per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_quoNeg <= 1'b0;
      r_remNeg <= 1'b0;
      r_quoMag <= '0;
      r_remMag <= '0;
      r_quoBcd <= '0;
      r_remBcd <= '0;
`ifdef DIVZ_FLAG_EN
      r_divz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt <= '0;
`ifdef DIVZ_FLAG_EN
            r_divz <= in_divz;
            if (in_divz) begin
              r_quoNeg <= 1'b0;
              r_remNeg <= 1'b0;
              r_quoMag <= '0;
              r_remMag <= '0;
              r_quoBcd <= 12'hFFF;
              r_remBcd <= 12'hFFF;
            end else
`endif
            begin
              r_quoNeg <= in_quo[DATA_W-1];
              r_remNeg <= in_rem[DATA_W-1];
              r_quoMag <= in_quo[DATA_W-1] ? -in_quo : in_quo;
              r_remMag <= in_rem[DATA_W-1] ? -in_rem : in_rem;
              r_quoBcd <= '0;
              r_remBcd <= '0;
            end
          end
        end
        CONV: begin
          r_cnt <= r_cnt + 4'd1;
`ifdef DIVZ_FLAG_EN
          if (!r_divz) begin
`else
          begin
`endif
            r_quoBcd <= 12'({addThree(r_quoBcd), r_quoMag[DATA_W-1]});
            r_remBcd <= 12'({addThree(r_remBcd), r_remMag[DATA_W-1]});
            r_quoMag <= {r_quoMag[DATA_W-2:0], 1'b0};
            r_remMag <= {r_remMag[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic.
  // Result fields are gated by DONE, so they read zero at all other times.
  // in_ready is also held low while reset is asserted.
  always_comb begin
    in_ready    = (r_state == IDLE) && rst_n;
    out_valid   = (r_state == DONE);
    out_quo_neg = 1'b0;
    out_quo_bcd = '0;
    out_rem_neg = 1'b0;
    out_rem_bcd = '0;
`ifdef DIVZ_FLAG_EN
    out_divz    = 1'b0;
`endif
    if (r_state == DONE) begin
      out_quo_neg = r_quoNeg;
      out_quo_bcd = r_quoBcd;
      out_rem_neg = r_remNeg;
      out_rem_bcd = r_remBcd;
`ifdef DIVZ_FLAG_EN
      out_divz    = r_divz;
`endif
    end
  end

endmodule

// File: tb/tb_div_result_bcd_formatter.sv
// tb_div_result_bcd_formatter
// Directed table of quotient/remainder pairs with hand-computed BCD results.
// Also contains hand-written sequences for output stall, mid-conversion reset
// and (when DIVZ_FLAG_EN is defined) the divide-by-zero path.
module tb_div_result_bcd_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_quo;
  logic [7:0]  in_rem;
  logic        out_valid;
  logic        out_ready;
  logic        out_quo_neg;
  logic [11:0] out_quo_bcd;
  logic        out_rem_neg;
  logic [11:0] out_rem_bcd;
`ifdef DIVZ_FLAG_EN
  logic        in_divz;
  logic        out_divz;
`endif

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [7:0]  quo;
    logic [7:0]  rem;
    logic        qNeg;
    logic [11:0] qBcd;
    logic        rNeg;
    logic [11:0] rBcd;
  } vec_t;

  vec_t vecs[10];

  div_result_bcd_formatter #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_quo     (in_quo),
    .in_rem     (in_rem),
`ifdef DIVZ_FLAG_EN
    .in_divz    (in_divz),
    .out_divz   (out_divz),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_quo_neg(out_quo_neg),
    .out_quo_bcd(out_quo_bcd),
    .out_rem_neg(out_rem_neg),
    .out_rem_bcd(out_rem_bcd)
  );

  always #5 clk = ~clk;

  // Hard stop in case a wait is ever mis-bounded
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Offers one pair once in_ready is seen, then scrambles the inputs.
  // Returns the number of edges (accept edge counted as 1) until out_valid is seen.
  task automatic applyStimulus(input logic [7:0] quo, input logic [7:0] rem, output int edges);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!in_ready && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_quo   = quo;
    in_rem   = rem;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_quo   = 8'hA5;
    in_rem   = 8'h5A;
    while (!out_valid && edges < 30) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  // Checks the displayed result and its latency, then (out_ready held high) the one-cycle pulse.
  task automatic checkResult(input string name, input vec_t v, input int edges, input int expEdges);
    checkOutput({name, "_latency"}, edges, expEdges);
    checkOutput({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({name, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    checkOutput({name, "_quo_neg"}, {31'd0, out_quo_neg}, {31'd0, v.qNeg});
    checkOutput({name, "_quo_bcd"}, {20'd0, out_quo_bcd}, {20'd0, v.qBcd});
    checkOutput({name, "_rem_neg"}, {31'd0, out_rem_neg}, {31'd0, v.rNeg});
    checkOutput({name, "_rem_bcd"}, {20'd0, out_rem_bcd}, {20'd0, v.rBcd});
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, "_pulse_end"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    int   edges;
    vec_t v;

    vecs[0] = '{8'h03, 8'h01, 1'b0, 12'h003, 1'b0, 12'h001};
    vecs[1] = '{8'hFD, 8'hFF, 1'b1, 12'h003, 1'b1, 12'h001};
    vecs[2] = '{8'h80, 8'h00, 1'b1, 12'h128, 1'b0, 12'h000};
    vecs[3] = '{8'h7F, 8'h05, 1'b0, 12'h127, 1'b0, 12'h005};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 12'h000, 1'b0, 12'h000};
    vecs[5] = '{8'hF4, 8'hFE, 1'b1, 12'h012, 1'b1, 12'h002};
    vecs[6] = '{8'h64, 8'h9C, 1'b0, 12'h100, 1'b1, 12'h100};
    vecs[7] = '{8'h81, 8'h01, 1'b1, 12'h127, 1'b0, 12'h001};
    vecs[8] = '{8'h3F, 8'hC1, 1'b0, 12'h063, 1'b1, 12'h063};
    vecs[9] = '{8'h59, 8'hB5, 1'b0, 12'h089, 1'b1, 12'h075};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_quo    = 8'h00;
    in_rem    = 8'h00;
    out_ready = 1'b1;
`ifdef DIVZ_FLAG_EN
    in_divz   = 1'b0;
`endif

    // Reset state
    #12;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_quo_bcd", {20'd0, out_quo_bcd}, 32'd0);
    checkOutput("reset_rem_bcd", {20'd0, out_rem_bcd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].quo, vecs[i].rem, edges);
      checkResult($sformatf("vec%0d", i), vecs[i], edges, 9);
`ifdef DIVZ_FLAG_EN
      checkOutput($sformatf("vec%0d_divz", i), {31'd0, out_divz}, 32'd0);
`endif
    end

    // Output stall: 10 / 3 held for 5 cycles while in_valid is pulsed
    out_ready = 1'b0;
    v = '{8'h0A, 8'h03, 1'b0, 12'h010, 1'b0, 12'h003};
    applyStimulus(v.quo, v.rem, edges);
    checkResult("stall", v, edges, 9);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      in_quo   = 8'h33;
      in_rem   = 8'h44;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      checkOutput($sformatf("stall%0d_quo", c), {20'd0, out_quo_bcd}, 32'h010);
      checkOutput($sformatf("stall%0d_rem", c), {20'd0, out_rem_bcd}, 32'h003);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall_release_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall_no_accept", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a conversion (count 4), then a clean pair
    @(negedge clk);
    in_valid = 1'b1;
    in_quo   = 8'h55;
    in_rem   = 8'h11;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_quo_bcd", {20'd0, out_quo_bcd}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_held_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    v = '{8'h0C, 8'h02, 1'b0, 12'h012, 1'b0, 12'h002};
    applyStimulus(v.quo, v.rem, edges);
    checkResult("after_rst", v, edges, 9);

`ifdef DIVZ_FLAG_EN
    // Divide-by-zero skips the conversion
    in_divz = 1'b1;
    v = '{8'h12, 8'h34, 1'b0, 12'hFFF, 1'b0, 12'hFFF};
    applyStimulus(v.quo, v.rem, edges);
    checkOutput("divz_flag", {31'd0, out_divz}, 32'd1);
    checkResult("divz", v, edges, 2);
    in_divz = 1'b0;
    v = '{8'h05, 8'h00, 1'b0, 12'h005, 1'b0, 12'h000};
    applyStimulus(v.quo, v.rem, edges);
    checkOutput("after_divz_flag", {31'd0, out_divz}, 32'd0);
    checkResult("after_divz", v, edges, 9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
